// File: rtl/seven_seg_pkg.sv
// Shared constants, register map and scan FSM state type for the seven-segment scan controller.
package seven_seg_pkg;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned PRE_W  = 16;
    localparam int unsigned DIG_W  = 6;

    localparam logic [ADDR_W-1:0] ADDR_CTRL     = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_PRESCALE = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd6;

    localparam int unsigned CTRL_SCAN_EN  = 0;
    localparam int unsigned CTRL_BLINK_EN = 1;

    localparam int unsigned DIG_DP    = 4;
    localparam int unsigned DIG_BLANK = 5;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ON    = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern (bit0=a .. bit6=g).
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0]       hex_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (hex_i)
            4'h0: seg_o = 7'h40;
            4'h1: seg_o = 7'h79;
            4'h2: seg_o = 7'h24;
            4'h3: seg_o = 7'h30;
            4'h4: seg_o = 7'h19;
            4'h5: seg_o = 7'h12;
            4'h6: seg_o = 7'h02;
            4'h7: seg_o = 7'h78;
            4'h8: seg_o = 7'h00;
            4'h9: seg_o = 7'h10;
            4'hA: seg_o = 7'h08;
            4'hB: seg_o = 7'h03;
            4'hC: seg_o = 7'h46;
            4'hD: seg_o = 7'h21;
            4'hE: seg_o = 7'h06;
            4'hF: seg_o = 7'h0E;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Avalon-MM slave that scans a bank of common-anode digits round-robin with
// a blanking gap between digits and an optional whole-display blink.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int unsigned       NUM_DIGITS       = 4,
    parameter logic [PRE_W-1:0]  PRESCALE_DEFAULT = 16'd49999,
    parameter int unsigned       BLINK_FRAMES     = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [DATA_W-1:0]     writedata,
    output logic [DATA_W-1:0]     readdata,
    output logic [SEG_W-1:0]      seg_out,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] digit_en_n
);

    localparam int unsigned         FRAME_W    = $clog2(BLINK_FRAMES + 1);
    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRAME_W-1:0]  LAST_FRAME = FRAME_W'(BLINK_FRAMES - 1);
    localparam logic [ADDR_W-1:0]   NUM_DIG_A  = ADDR_W'(NUM_DIGITS);

    logic [DIG_W-1:0]      digit_q [NUM_DIGITS];
    logic [1:0]            ctrl_q;
    logic [PRE_W-1:0]      prescale_q;

    scan_state_t           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [PRE_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_W-1:0]    frame_q, frame_d;
    logic                  phase_q, phase_d;

    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;

    logic                  wr_c;
    logic                  tick_c;
    logic [DIG_W-1:0]      cur_digit_c;
    logic [SEG_W-1:0]      seg_dec_c;
    logic                  unused_wdata;

    assign wr_c         = chipselect && !write_n;
    assign tick_c       = (cnt_q == '0);
    assign cur_digit_c  = digit_q[idx_q];
    assign unused_wdata = ^writedata[DATA_W-1:PRE_W];

    hex_to_seg u_hex_to_seg (
        .hex_i (cur_digit_c[3:0]),
        .seg_o (seg_dec_c)
    );

    // Software-visible register file; each write lands atomically in one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                digit_q[i] <= '0;
            end
            ctrl_q     <= '0;
            prescale_q <= PRESCALE_DEFAULT;
        end else if (wr_c) begin
            if (address < NUM_DIG_A) begin
                digit_q[address[IDX_W-1:0]] <= writedata[DIG_W-1:0];
            end else if (address == ADDR_CTRL) begin
                ctrl_q <= writedata[1:0];
            end else if (address == ADDR_PRESCALE) begin
                prescale_q <= writedata[PRE_W-1:0];
            end
        end
    end

    // Scan sequencing: prescaler, digit index, frame counter and blink phase.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        phase_d = phase_q;
        if (!ctrl_q[CTRL_SCAN_EN]) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            frame_d = '0;
            phase_d = 1'b0;
        end else begin
            if (state_q != IDLE) begin
                cnt_d = tick_c ? prescale_q : cnt_q - PRE_W'(1);
            end
            case (state_q)
                IDLE: begin
                    state_d = ON;
                    idx_d   = '0;
                    cnt_d   = prescale_q;
                end
                ON: begin
                    if (tick_c) begin
                        state_d = BLANK;
                    end
                end
                BLANK: begin
                    if (tick_c) begin
                        state_d = ON;
                        if (idx_q == LAST_IDX) begin
                            idx_d = '0;
                            if (frame_q == LAST_FRAME) begin
                                frame_d = '0;
                                phase_d = ~phase_q;
                            end else begin
                                frame_d = frame_q + FRAME_W'(1);
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
            if (!ctrl_q[CTRL_BLINK_EN]) begin
                phase_d = 1'b0;
            end
        end
    end

    // Display drive; a digit stays enabled even when blanked or blinked off.
    always_comb begin
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        en_d  = '1;
        if (state_q == ON && ctrl_q[CTRL_SCAN_EN]) begin
            en_d = ~(NUM_DIGITS'(1) << idx_q);
            if (!cur_digit_c[DIG_BLANK] && !phase_q) begin
                seg_d = seg_dec_c;
                dp_d  = ~cur_digit_c[DIG_DP];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            frame_q <= '0;
            phase_q <= 1'b0;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
            en_q    <= '1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            en_q    <= en_d;
        end
    end

    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign digit_en_n = en_q;

    // Zero-wait-state read mux.
    always_comb begin
        readdata = '0;
        if (chipselect) begin
            if (address < NUM_DIG_A) begin
                readdata = {(DATA_W - DIG_W)'(0), digit_q[address[IDX_W-1:0]]};
            end else begin
                case (address)
                    ADDR_CTRL:     readdata = {30'd0, ctrl_q};
                    ADDR_PRESCALE: readdata = {16'd0, prescale_q};
                    ADDR_STATUS:   readdata = {28'd0, (state_q == ON), phase_q, idx_q};
                    default:       readdata = '0;
                endcase
            end
        end
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Avalon-MM slave that owns a multiplexed bank of common-anode seven-segment digits and time-shares the single segment bus between them.
- Software writes one hex nibble per digit plus control. The block decodes each nibble, scans the digits round-robin with a blanking gap between digits (anti-ghosting), and optionally blinks the whole display.
- Sits on the Nios system interconnect beside the other PIO slaves and replaces per-digit 7-bit PIO ports.

Parameters:
- NUM_DIGITS, 4, number of scanned digits; range 1..4, fits address space.
- PRESCALE_DEFAULT, 16'd49999, reset value of the prescaler reload register (1 ms tick at 50 MHz).
- BLINK_FRAMES, 64, number of complete scan frames per blink half-period.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data; combinational, zero wait states, read latency 0
- seg_out  out  7  segments, active-low; bit0=a … bit6=g
- dp_out  out  1  decimal point, active-low
- digit_en_n  out  NUM_DIGITS  digit anode enables, active-low; at most one bit low at any time

Behaviour:
- Reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values of outputs: seg_out=7'h7F, dp_out=1, digit_en_n=all 1.
- Reset values of registers: digit registers=0, ctrl=0, prescale=PRESCALE_DEFAULT. FSM=IDLE, idx=0, frame_cnt=0, blink_phase=0.
- Register map. A write occurs when chipselect && !write_n.
  - 0..NUM_DIGITS-1: DIGITn. [3:0] hex value, [4] dp on, [5] force blank. Read returns [5:0], zero-extended.
  - 4: CTRL. [0] scan_en, [1] blink_en.
  - 5: PRESCALE. [15:0] reload value.
  - 6: STATUS, read-only. [1:0] idx, [2] blink_phase, [3] fsm state==ON.
  - 7 and any digit address >= NUM_DIGITS: writes ignored, reads return 0.
- Prescaler:
  - Down-counter cnt, running only while state != IDLE.
  - When cnt==0: tick=1 and cnt<=PRESCALE. Otherwise cnt<=cnt-1. Tick period is PRESCALE+1 cycles.
  - PRESCALE=0 gives a tick every cycle.
  - A PRESCALE write takes effect at the next reload. It never truncates the count in progress.
- FSM states IDLE, ON, BLANK:
  - IDLE: all outputs off. When scan_en=1: go to ON with idx=0 and cnt=PRESCALE.
  - ON: drive digit idx. On tick: go to BLANK.
  - BLANK: all outputs off. On tick: go to ON and advance idx. idx wraps from NUM_DIGITS-1 to 0. On wrap, frame_cnt increments.
  - scan_en=0 in any state: next cycle IDLE; outputs off, idx=0, cnt=0, frame_cnt=0, blink_phase=0.
- Blink:
  - When blink_en=1 and frame_cnt reaches BLINK_FRAMES-1 on a wrap: frame_cnt<=0 and blink_phase toggles.
  - When blink_en=0: blink_phase is held at 0.
  - blink_phase=1 forces ON-state outputs off. Sequencing continues.
- Outputs are registered. With state/idx/data at cycle t, outputs appear at t+1.
  - In ON: digit_en_n[idx]=0, seg_out=decode(DIGIT[idx][3:0]), dp_out=!DIGIT[idx][4].
  - If DIGIT[idx][5] or blink_phase is set: seg_out=7'h7F, dp_out=1, and digit_en_n remains asserted.
- A digit register write during ON of that digit is visible on outputs 2 cycles after the write cycle. No tearing within a digit: a single register update is applied atomically.
- Reset asserted mid-scan: immediate return to all reset values, asynchronously.
- Decode table (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E

Decomposition:
- Package seven_seg_pkg holds:
  - register address constants: ADDR_CTRL=4, ADDR_PRESCALE=5, ADDR_STATUS=6;
  - CTRL bit indices;
  - the scan_state_t enum {IDLE, ON, BLANK};
  - SEG_OFF=7'h7F.
- One sub-module, hex_to_seg: purely combinational 4-bit to 7-bit active-low decoder. It is instantiated once, on the idx-muxed nibble.

Test Plan:
- Reset: reset_n low mid-scan.
  - Outputs are 7F/1/F within the same cycle.
  - Reads: CTRL=0, PRESCALE=49999, DIGIT0=0.
- Scan timing: PRESCALE=2, DIGIT0..3 = 0,1,2,3, CTRL=1.
  - digit_en_n sequence E(3 cycles), F(3), D(3), F(3), B, F, 7, F, then repeats.
  - seg_out is 40, 79, 24, 30 during the respective ON windows.
  - digit_en_n is never low on two bits at once.
- Decode and attributes:
  - DIGIT1=0x18 (8, dp) gives seg_out=00, dp_out=0.
  - DIGIT2=0x2F (blank) gives seg_out=7F with digit_en_n=B.
  - DIGIT3=0xF gives seg_out=0E.
- Blink: parameter BLINK_FRAMES=2, PRESCALE=0, CTRL=3.
  - Segments are lit for 2 frames (16 cycles), then 7F for 2 frames, alternately.
  - STATUS[2] toggles every 16 cycles.
- Disable and reconfigure:
  - CTRL=0 written during digit 2 ON: next cycle outputs off, STATUS idx=0. Re-enable restarts at digit 0.
  - PRESCALE write mid-period does not change the current period length; the new value applies from the next reload.
- Address decode:
  - A write to address 7 changes nothing.
  - Reads of addresses 7 and 6 return 0 and the correct status.
  - readdata is valid in the same cycle as chipselect.
